game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 165 ++++++++++++++++
 tb/tb_game_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Match sequencer for a two-player ball game: serve hold, rally, point scoring and game over.
// Define GAME_SEQUENCER_PAUSE_EN to build the pause/resume feature.
module game_sequencer #(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] score_evt,
    output logic       phys_rst_n,
    output logic       phys_step,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic [2:0] game_state,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
        S_OVER   = 3'd4,
        S_PAUSED = 3'd5
    } state_t;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_VAL = 8'(SERVE_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [1:0] evt_q, evt_d;
    logic [3:0] left_q, left_d;
    logic [3:0] right_q, right_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] left_upd, right_upd;

`ifdef GAME_SEQUENCER_PAUSE_EN
    logic pause_q;
    logic pause_rise;

    always_ff @(posedge clk) begin
        if (rst) pause_q <= 1'b0;
        else     pause_q <= pause;
    end

    assign pause_rise = pause & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = pause;
`endif

    // A simultaneous event (11) matches neither compare, so the rally is void.
    assign left_upd  = (evt_q == 2'b10 && left_q  != 4'hF) ? left_q  + 4'd1 : left_q;
    assign right_upd = (evt_q == 2'b01 && right_q != 4'hF) ? right_q + 4'd1 : right_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            serve_cnt_q <= 8'd0;
            evt_q       <= 2'b00;
            left_q      <= 4'd0;
            right_q     <= 4'd0;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            evt_q       <= evt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            winner_q    <= winner_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        evt_d       = evt_q;
        left_d      = left_q;
        right_d     = right_q;
        winner_d    = winner_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_VAL;
                    left_d      = 4'd0;
                    right_d     = 4'd0;
                    winner_d    = 2'b00;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt_q <= 8'd1) begin
                        serve_cnt_d = 8'd0;
                        state_d     = S_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (score_evt != 2'b00) begin
                    evt_d   = score_evt;
                    state_d = S_POINT;
                end
`ifdef GAME_SEQUENCER_PAUSE_EN
                else if (pause_rise) begin
                    state_d = S_PAUSED;
                end
`endif
            end
            S_POINT: begin
                left_d  = left_upd;
                right_d = right_upd;
                if (left_upd == WIN_VAL) begin
                    state_d  = S_OVER;
                    winner_d = 2'b10;
                end else if (right_upd == WIN_VAL) begin
                    state_d  = S_OVER;
                    winner_d = 2'b01;
                end else begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_VAL;
                end
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            S_PAUSED: begin
                if (pause_rise) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Physics is released only while the ball is live or frozen in place.
    always_comb begin
        phys_rst_n = 1'b0;
        phys_step  = 1'b0;
        case (state_q)
            S_PLAY: begin
                phys_rst_n = 1'b1;
                phys_step  = frame_tick;
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            S_PAUSED: phys_rst_n = 1'b1;
`endif
            default: begin
                phys_rst_n = 1'b0;
                phys_step  = 1'b0;
            end
        endcase
    end

    assign left_score  = left_q;
    assign right_score = right_q;
    assign game_state  = state_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural match model predicts every cycle's outputs.
module tb_game_sequencer;

    localparam int WIN = 11;
    localparam int SF  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] score_evt = 2'b00;
    logic       phys_rst_n, phys_step;
    logic [3:0] left_score, right_score;
    logic [2:0] game_state;
    logic [1:0] winner;

    game_sequencer #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
        .score_evt(score_evt), .phys_rst_n(phys_rst_n), .phys_step(phys_step),
        .left_score(left_score), .right_score(right_score), .game_state(game_state),
        .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       prn;
        logic       step;
        logic [3:0] l;
        logic [3:0] r;
        logic [2:0] st;
        logic [1:0] w;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: match described as a mode number plus plain integer counters.
    int m_mode = 0, m_serve = 0, m_l = 0, m_r = 0, m_win = 0, m_pend = 0, m_prev_pause = 0;

    function automatic obs_t predict(input logic t);
        obs_t o;
        o.prn  = (m_mode == 2 || m_mode == 5);
        o.step = (m_mode == 2) && t;
        o.l    = 4'(m_l);
        o.r    = 4'(m_r);
        o.st   = 3'(m_mode);
        o.w    = 2'(m_win);
        return o;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic t,
                              input logic [1:0] e, input logic p);
        bit rise;
        rise = (p && m_prev_pause == 0);
        if (r) begin
            m_mode = 0; m_serve = 0; m_l = 0; m_r = 0; m_win = 0; m_prev_pause = 0;
            return;
        end
        m_prev_pause = int'(p);
        if (m_mode == 0 || m_mode == 4) begin
            if (s) begin
                m_l = 0; m_r = 0; m_win = 0; m_serve = SF; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (t) begin
                m_serve = m_serve - 1;
                if (m_serve == 0) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (e != 2'b00) begin
                m_pend = int'(e); m_mode = 3;
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            else if (rise) m_mode = 5;
`endif
        end else if (m_mode == 3) begin
            if (m_pend == 2 && m_l < 15) m_l = m_l + 1;
            if (m_pend == 1 && m_r < 15) m_r = m_r + 1;
            if (m_l == WIN) begin
                m_mode = 4; m_win = 2;
            end else if (m_r == WIN) begin
                m_mode = 4; m_win = 1;
            end else begin
                m_serve = SF; m_mode = 1;
            end
        end else if (m_mode == 5) begin
            if (rise) m_mode = 2;
        end else begin
            m_mode = 0;
        end
    endtask

    // One bench cycle: drive inputs after the edge, queue the prediction, advance the model.
    task automatic cyc(input logic r, input logic s, input logic t,
                       input logic [1:0] e, input logic p);
        #2;
        rst = r; start = s; frame_tick = t; score_evt = e; pause = p;
        exp_q.push_back(predict(t));
        @(posedge clk);
        model_step(r, s, t, e, p);
    endtask

    task automatic serve_to_play(input logic s);
        for (int i = 0; i < 2 * SF; i++) cyc(1'b0, s, i[0], 2'b00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    endtask

    task automatic rally(input logic [1:0] e);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, e, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic toggle_pause();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{prn: phys_rst_n, step: phys_step, l: left_score, r: right_score,
                  st: game_state, w: winner};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_outputs t=%0t got st=%0d l=%0d r=%0d w=%b prn=%b step=%b expected st=%0d l=%0d r=%0d w=%b prn=%b step=%b",
                          $time, a.st, a.l, a.r, a.w, a.prn, a.step, e.st, e.l, e.r, e.w, e.prn, e.step);
        end
    end

    initial begin
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);

        // Basic serve, left point, void rally, right point.
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        serve_to_play(1'b1);
        rally(2'b10);
        serve_to_play(1'b0);
        rally(2'b11);
        serve_to_play(1'b0);
        rally(2'b01);

        // Left runs to the winning score, then events and a late start are checked in OVER.
        for (int k = 0; k < WIN - 1; k++) begin
            serve_to_play(1'b0);
            rally(2'b10);
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 2'($urandom_range(1, 3)), 1'b0);

        // Restart, build 5/7 and reset mid-rally.
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            serve_to_play(1'b0);
            rally(k < 5 ? 2'b10 : 2'b01);
        end
        serve_to_play(1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Reset mid-serve.
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);

        // Pause edges: ignored by the default build, honoured when the feature is built.
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        serve_to_play(1'b0);
        toggle_pause();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        toggle_pause();
        rally(2'b10);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) == 0,
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
